// File: rtl/pc_stack_ctrl_if.sv
// Program-counter / return-stack control bus.
// Requests and interrupt inputs in; fetch address, kill and status out.
interface pc_stack_ctrl_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 8
);
  localparam int LW = $clog2(STACK_DEPTH) + 1;

  logic                  pause;
  logic                  goto;
  logic                  call;
  logic                  ret;
  logic                  skip;
  logic [ADDR_WIDTH-1:0] goto_addr;
  logic                  intr_req;
  logic                  gie;

  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  kill;
  logic                  intr_ack;
  logic [LW-1:0]         stack_level;
  logic                  stopped;
  logic                  error;

  modport master (
    output pause, goto, call, ret, skip,
    output goto_addr, intr_req, gie,
    input  pc_out, kill, intr_ack,
    input  stack_level, stopped, error
  );

  modport slave (
    input  pause, goto, call, ret, skip,
    input  goto_addr, intr_req, gie,
    output pc_out, kill, intr_ack,
    output stack_level, stopped, error
  );
endinterface

// File: rtl/pc_stack_ctrl.sv
// PC sequencer with LIFO return stack, interrupt entry, halt and fault states.
// Ports: clk, reset (async high), bus = pc_stack_ctrl_if.slave.
module pc_stack_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0,
  parameter int INTR_VECTOR = 4,
  parameter int STACK_WRAP  = 0
) (
  input  logic            clk,
  input  logic            reset,
  pc_stack_ctrl_if.slave  bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int LW = $clog2(STACK_DEPTH) + 1;
  localparam int PW = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t        state_q, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic          kill_q, kill_n;
  logic [LW-1:0] lvl_q, lvl_n;
  logic [PW-1:0] top_q, top_n;
  logic          push;
  logic          ack;

  logic [AW-1:0] stk [STACK_DEPTH];

  logic          live;
  logic          irq;
  logic          do_ret, do_call, do_goto;
  logic          do_intr, do_skip;
  logic          full;
  logic [AW-1:0] tos;
  logic [AW-1:0] target;

  // A killed slot still advances the PC but
  // its control requests are dropped.
  assign live    = ~kill_q;
  assign irq     = bus.intr_req & bus.gie;
  assign do_ret  = live & bus.ret;
  assign do_call = live & bus.call & ~bus.ret;
  assign do_goto = live & bus.goto
                 & ~bus.call & ~bus.ret;
  assign do_intr = live & irq & ~bus.ret
                 & ~bus.call & ~bus.goto;
  assign do_skip = live & bus.skip & ~irq
                 & ~bus.ret & ~bus.call & ~bus.goto;

  assign full   = (lvl_q == LW'(STACK_DEPTH));
  assign tos    = stk[top_q - PW'(1)];
  assign target = do_call ? bus.goto_addr
                          : AW'(INTR_VECTOR);

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    kill_n  = kill_q;
    lvl_n   = lvl_q;
    top_n   = top_q;
    push    = 1'b0;
    ack     = 1'b0;
    if (!bus.pause && state_q == RUN) begin
      kill_n = 1'b0;
      unique case (1'b1)
        do_ret: begin
          if (lvl_q == '0) begin
            state_n = FAULT;
          end else begin
            pc_n   = tos;
            top_n  = top_q - PW'(1);
            lvl_n  = lvl_q - LW'(1);
            kill_n = 1'b1;
          end
        end
        do_call, do_intr: begin
          if (full && STACK_WRAP == 0) begin
            state_n = FAULT;
          end else begin
            // When full with wrap, top_q already
            // points at the oldest slot.
            push   = 1'b1;
            pc_n   = target;
            top_n  = top_q + PW'(1);
            if (!full) lvl_n = lvl_q + LW'(1);
            kill_n = 1'b1;
            ack    = do_intr;
          end
        end
        do_goto: begin
          pc_n   = bus.goto_addr;
          kill_n = 1'b1;
        end
        do_skip: begin
          pc_n   = pc_q + AW'(1);
          kill_n = 1'b1;
        end
        default: begin
          if (&pc_q) state_n = HALT;
          else       pc_n    = pc_q + AW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= AW'(RESET_ADDR);
      kill_q  <= 1'b0;
      lvl_q   <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      kill_q  <= kill_n;
      lvl_q   <= lvl_n;
      top_q   <= top_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[top_q] <= pc_q;
  end

  assign bus.pc_out      = pc_q;
  assign bus.kill        = kill_q;
  assign bus.intr_ack    = ack & ~reset;
  assign bus.stack_level = lvl_q;
  assign bus.stopped     = (state_q != RUN);
  assign bus.error       = (state_q == FAULT);
endmodule

// File: doc/pc_stack_ctrl.md
PC_STACK_CTRL -- requirements
Module: pc_stack_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, program-address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-004 SHALL have parameter INTR_VECTOR, default 4, interrupt entry address.
REQ-005 SHALL have parameter STACK_WRAP, default 0; 0 = overflow is an error, 1 = overflow discards the oldest entry.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: pause in 1, freeze; goto in 1, jump request; call in 1, call request; ret in 1, return request; skip in 1, skip-next request; goto_addr in ADDR_WIDTH, jump/call target.
REQ-008 SHALL have ports: intr_req in 1, level interrupt request; gie in 1, global interrupt enable.
REQ-009 SHALL have ports: pc_out out ADDR_WIDTH, fetch address; kill out 1, squash in-flight instruction; intr_ack out 1, interrupt-taken pulse; stack_level out clog2(STACK_DEPTH)+1, occupied entries; stopped out 1, core halted; error out 1, stack fault.

Function
REQ-010 SHALL implement states RUN, HALT, FAULT; stopped = 1 in HALT or FAULT, error = 1 in FAULT only.
REQ-011 SHALL hold all registers unchanged in any cycle where pause = 1, in any state.
REQ-012 SHALL ignore goto, call, ret, skip in any cycle where kill = 1 (killed instruction).
REQ-013 SHALL, in RUN with pause = 0, apply exactly one action per cycle, priority: ret > call > goto > interrupt > skip > sequential.
REQ-014 ret: pc_out <= top of stack, stack_level decrements.
REQ-015 call: push current pc_out, pc_out <= goto_addr, stack_level increments.
REQ-016 goto (call = 0): pc_out <= goto_addr, stack unchanged.
REQ-017 interrupt taken when intr_req = 1, gie = 1, kill = 0, no ret/call/goto: push pc_out, pc_out <= INTR_VECTOR, intr_ack = 1 for that one cycle (combinational).
REQ-018 skip: pc_out <= pc_out + 1.
REQ-019 sequential: pc_out <= pc_out + 1, modulo 2^ADDR_WIDTH.
REQ-020 kill SHALL be a register set to 1 in the cycle after ret, call, goto, interrupt or skip is applied, otherwise 0; held under pause.
REQ-021 sequential increment from all-ones address SHALL instead enter HALT, pc_out unchanged; HALT exits only by reset.
REQ-022 ret with stack_level = 0 SHALL enter FAULT, pc_out unchanged.
REQ-023 call or interrupt with stack_level = STACK_DEPTH: STACK_WRAP = 0 enters FAULT, pc_out unchanged; STACK_WRAP = 1 overwrites oldest entry, jumps, stack_level stays STACK_DEPTH.
REQ-024 in HALT or FAULT, pc_out, stack and kill SHALL hold, intr_ack = 0.
REQ-025 stack SHALL be LIFO circular buffer with top pointer; contents need no reset.

Reset
REQ-026 reset = 1 SHALL immediately (no clock) force pc_out = RESET_ADDR, state RUN, kill = 0, stack_level = 0, intr_ack = 0, stopped = 0, error = 0.
REQ-027 reset asserted mid-call/interrupt SHALL abandon it; first rising edge after deassertion performs a normal action from RESET_ADDR.

Verification
REQ-028 reset, 3 idle cycles -> pc_out 0,1,2,3; kill 0 throughout.
REQ-029 at pc_out 0x010 call goto_addr 0x200; next cycle kill 1 (call input ignored); later ret -> pc_out 0x010, stack_level 1->0, kill 1 one cycle.
REQ-030 intr_req 1, gie 1 at pc_out 0x020 -> intr_ack pulse, pc_out 0x004, stack_level 1; same cycle with goto 0x300 -> goto wins, no intr_ack.
REQ-031 9 nested calls, STACK_DEPTH 8, STACK_WRAP 0 -> 9th gives error 1, stopped 1, pc_out frozen; STACK_WRAP 1 -> jump taken, stack_level 8, 8 rets return newest 8 addresses.
REQ-032 ret at stack_level 0 -> error 1; pc_out 0xFFF sequential -> stopped 1, error 0; pause held 5 cycles mid-run -> all outputs frozen, then resume.
REQ-033 skip at pc_out 0x040 -> pc_out 0x041, kill 1 next cycle, goto asserted during kill ignored.
